// File: rtl/univ_shift_reg_pkg.sv
// univ_shift_reg_pkg
//   Shared definitions for the universal shift register: the ctrl operation
//   encodings used by the datapath and by anything driving it.
package univ_shift_reg_pkg;

   typedef enum logic [2:0] {
      OP_HOLD = 3'b000,
      OP_SHR  = 3'b001,
      OP_SHL  = 3'b010,
      OP_LOAD = 3'b011,
      OP_ROR  = 3'b100,
      OP_ROL  = 3'b101
   } op_e;

   localparam int OP_W = 3;

endpackage

// File: rtl/shift_bit_cnt.sv
// shift_bit_cnt
//   Counts shifts since the last load/clear and emits a registered one-cycle
//   done pulse in the cycle after the count wraps from N-1 back to 0. The wrap
//   is at N, so non-power-of-two widths never reach values >= N.
// Ports:
//   clk      - clock, rising edge
//   reset_n  - asynchronous active-low reset
//   clr      - synchronous clear of cnt and done (highest priority)
//   inc      - one shift happened this cycle
//   ld       - parallel load this cycle: restart the count
//   cnt      - shifts since last load/clear, 0..N-1
//   done     - word-complete pulse
module shift_bit_cnt #(
   parameter int N  = 8,
   parameter int CW = 3
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          clr,
   input  logic          inc,
   input  logic          ld,
   output logic [CW-1:0] cnt,
   output logic          done
);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          done_q, done_d;
   logic          wrap;

   assign wrap = (cnt_q == CW'(N - 1));

   always_comb begin
      cnt_d  = cnt_q;
      done_d = 1'b0;
      if (ld) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d  = wrap ? '0 : cnt_q + 1'b1;
         done_d = wrap;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else if (clr) begin
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign cnt  = cnt_q;
   assign done = done_q;

endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg
//   N-bit universal shift register: hold, shift right/left with serial inputs,
//   parallel load and (optionally) rotate right/left. A shift counter reports
//   shifts since the last load/clear and pulses done once per N shifts.
//   Build option: define UNIV_SHIFT_REG_ROTATE_EN to enable ROR/ROL; without it
//   those codes act as HOLD and do not count.
// Ports:
//   clk, reset_n    - clock (rising edge), asynchronous active-low reset
//   clr             - synchronous clear, overrides en/ctrl
//   en              - operation enable; 0 holds state
//   ctrl            - operation select (univ_shift_reg_pkg::op_e)
//   s_in_l, s_in_r  - serial inputs entering at MSB (SHR) / LSB (SHL)
//   d               - parallel load data
//   q               - register contents
//   s_out_r/s_out_l - r[0] / r[N-1]
//   cnt, done       - shift count and word-complete pulse
module univ_shift_reg
   import univ_shift_reg_pkg::*;
#(
   parameter int N = 8,
   localparam int CW = $clog2(N)
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            clr,
   input  logic            en,
   input  logic [OP_W-1:0] ctrl,
   input  logic            s_in_l,
   input  logic            s_in_r,
   input  logic [N-1:0]    d,
   output logic [N-1:0]    q,
   output logic            s_out_r,
   output logic            s_out_l,
   output logic [CW-1:0]   cnt,
   output logic            done
);

   logic [N-1:0] r_q, r_d;
   logic         shift, ld;

   always_comb begin
      r_d   = r_q;
      shift = 1'b0;
      ld    = 1'b0;
      if (en) begin
         case (ctrl)
            OP_SHR: begin
               r_d   = {s_in_l, r_q[N-1:1]};
               shift = 1'b1;
            end
            OP_SHL: begin
               r_d   = {r_q[N-2:0], s_in_r};
               shift = 1'b1;
            end
            OP_LOAD: begin
               r_d = d;
               ld  = 1'b1;
            end
`ifdef UNIV_SHIFT_REG_ROTATE_EN
            OP_ROR: begin
               r_d   = {r_q[0], r_q[N-1:1]};
               shift = 1'b1;
            end
            OP_ROL: begin
               r_d   = {r_q[N-2:0], r_q[N-1]};
               shift = 1'b1;
            end
`endif
            default: ; // HOLD and reserved codes
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  r_q <= '0;
      else if (clr)  r_q <= '0;
      else           r_q <= r_d;
   end

   shift_bit_cnt #(.N(N), .CW(CW)) u_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (clr),
      .inc     (shift),
      .ld      (ld),
      .cnt     (cnt),
      .done    (done)
   );

   assign q       = r_q;
   assign s_out_r = r_q[0];
   assign s_out_l = r_q[N-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;
   import univ_shift_reg_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n;
   // N=8 instance
   logic       clr, en, s_in_l, s_in_r;
   logic [2:0] ctrl;
   logic [7:0] d, q;
   logic       s_out_r, s_out_l, done;
   logic [2:0] cnt;
   // N=5 instance
   logic       clr5, en5, s_in_l5, s_in_r5;
   logic [2:0] ctrl5;
   logic [4:0] d5, q5;
   logic       s_out_r5, s_out_l5, done5;
   logic [2:0] cnt5;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   univ_shift_reg #(.N(8)) dut (
      .clk(clk), .reset_n(reset_n), .clr(clr), .en(en), .ctrl(ctrl),
      .s_in_l(s_in_l), .s_in_r(s_in_r), .d(d), .q(q), .s_out_r(s_out_r),
      .s_out_l(s_out_l), .cnt(cnt), .done(done)
   );

   univ_shift_reg #(.N(5)) dut5 (
      .clk(clk), .reset_n(reset_n), .clr(clr5), .en(en5), .ctrl(ctrl5),
      .s_in_l(s_in_l5), .s_in_r(s_in_r5), .d(d5), .q(q5), .s_out_r(s_out_r5),
      .s_out_l(s_out_l5), .cnt(cnt5), .done(done5)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // advance one rising edge, then settle 1 time unit before sampling
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] a5;
      a5 = 8'hA5;
      reset_n = 1'b0;
      clr = 0; en = 0; ctrl = OP_HOLD; s_in_l = 0; s_in_r = 0; d = '0;
      clr5 = 0; en5 = 0; ctrl5 = OP_HOLD; s_in_l5 = 0; s_in_r5 = 0; d5 = '0;
      step(); step();
      check("rst_q", q, 0);
      check("rst_cnt", cnt, 0);
      check("rst_done", done, 0);
      reset_n = 1'b1;

      // LOAD A5 then 8x SHR
      en = 1; ctrl = OP_LOAD; d = 8'hA5;
      step();
      check("ld_q", q, 8'hA5);
      check("ld_cnt", cnt, 0);
      ctrl = OP_SHR; s_in_l = 0;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("shr_sout_r%0d", i), s_out_r, a5[i]);
         step();
         check($sformatf("shr_done%0d", i), done, (i == 7) ? 1 : 0);
         check($sformatf("shr_cnt%0d", i), cnt, (i + 1) % 8);
      end
      check("shr_q_end", q, 8'h00);
      ctrl = OP_HOLD;
      step();
      check("shr_done_drop", done, 0);

      // SHL
      ctrl = OP_LOAD; d = 8'h81;
      step();
      ctrl = OP_SHL; s_in_r = 1;
      step();
      check("shl_q", q, 8'h03);
      check("shl_sout_l", s_out_l, 0);
      check("shl_cnt", cnt, 1);

      // async reset mid-word
      step(); step(); step();   // q=1F, cnt=4
      check("pre_rst_cnt", cnt, 4);
      #2 reset_n = 1'b0;
      #1;
      check("arst_q", q, 0);
      check("arst_cnt", cnt, 0);
      check("arst_sout_r", s_out_r, 0);
      ctrl = OP_HOLD;
      step();
      reset_n = 1'b1;
      ctrl = OP_SHL; s_in_r = 1;
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("post_rst_done%0d", i), done, 0);
      end
      check("post_rst_cnt", cnt, 4);
      check("post_rst_q", q, 8'h0F);

      // rotate
      ctrl = OP_LOAD; d = 8'h01;
      step();
      ctrl = OP_ROL;
      for (int i = 0; i < 8; i++) begin
         step();
`ifdef UNIV_SHIFT_REG_ROTATE_EN
         check($sformatf("rol_done%0d", i), done, (i == 7) ? 1 : 0);
`else
         check($sformatf("rol_off_done%0d", i), done, 0);
`endif
      end
      check("rol_q", q, 8'h01);
`ifndef UNIV_SHIFT_REG_ROTATE_EN
      check("rol_off_cnt", cnt, 0);
`endif
      ctrl = OP_HOLD;
      step();
      check("rol_done_drop", done, 0);

      // reserved codes hold, LOAD restarts count
      ctrl = OP_LOAD; d = 8'h3C;
      step();
      ctrl = OP_SHR; s_in_l = 0;
      step();
      ctrl = 3'b111;
      step();
      check("rsv_q", q, 8'h1E);
      check("rsv_cnt", cnt, 1);
      ctrl = OP_LOAD; d = 8'hC3;
      step();
      check("reload_cnt", cnt, 0);
      check("reload_q", q, 8'hC3);

      // clr priority, en=0 hold
      ctrl = OP_SHR;
      step();
      clr = 1; en = 1; ctrl = OP_SHR;
      step();
      check("clr_q", q, 0);
      check("clr_cnt", cnt, 0);
      clr = 0; en = 0; ctrl = OP_LOAD; d = 8'hFF;
      step();
      check("en0_q", q, 0);
      check("en0_cnt", cnt, 0);

      // N=5: 10x SHR with s_in_l=1
      en5 = 1; ctrl5 = OP_LOAD; d5 = 5'b10110;
      step();
      check("n5_ld", q5, 5'h16);
      ctrl5 = OP_SHR; s_in_l5 = 1;
      for (int i = 1; i <= 10; i++) begin
         step();
         check($sformatf("n5_done%0d", i), done5, (i % 5 == 0) ? 1 : 0);
         check($sformatf("n5_cnt%0d", i), cnt5, i % 5);
      end
      check("n5_q", q5, 5'h1F);
      ctrl5 = OP_HOLD;
      step();
      check("n5_done_drop", done5, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter N, default 8, register width in bits; SHALL be >= 2.
REQ-002 Derived localparam CW = clog2(N), default 3, bit-counter width; SHALL NOT be overridden.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 clr  input  1  synchronous clear of register, counter and done.
REQ-006 en  input  1  operation enable; 0 = hold all state.
REQ-007 ctrl  input  3  operation select (encoding per REQ-012).
REQ-008 s_in_l  input  1  serial input entering at MSB on shift right.
REQ-009 s_in_r  input  1  serial input entering at LSB on shift left.
REQ-010 d  input  N  parallel load data.
REQ-011 q, s_out_r, s_out_l, cnt, done: outputs of width N, 1, 1, CW and 1; meanings are register contents, r[0], r[N-1], shifts since last load/clear, and word-complete pulse.

Function
REQ-012 Operation encoding:
- 000 HOLD
- 001 SHR: r <= {s_in_l, r[N-1:1]}
- 010 SHL: r <= {r[N-2:0], s_in_r}
- 011 LOAD: r <= d
- 100 ROR: r <= {r[0], r[N-1:1]}
- 101 ROL: r <= {r[N-2:0], r[N-1]}
- 110, 111: HOLD
REQ-013 Operations SHALL take effect only when en=1; en=0 holds r, cnt and done is driven 0.
REQ-014 clr=1 SHALL have priority over en and ctrl: next cycle r=0, cnt=0, done=0.
REQ-015 q SHALL equal r; s_out_r = r[0] and s_out_l = r[N-1], both combinational from r with zero added latency.
REQ-016 Each SHR/SHL/ROR/ROL with en=1 is one "shift"; each shift SHALL increment cnt.
REQ-017 When a shift occurs with cnt=N-1, cnt SHALL wrap to 0 and done SHALL be 1 for exactly the following cycle.
REQ-018 The wrap SHALL be at N, not 2^CW, including when N is not a power of two.
REQ-019 done SHALL be a registered single-cycle pulse; it is 0 in any cycle not immediately following a wrapping shift.
REQ-020 LOAD SHALL set cnt=0 and done=0 regardless of prior cnt.
REQ-021 HOLD and reserved codes SHALL leave r and cnt unchanged and drive done 0.
REQ-022 Back-to-back shifts SHALL sustain one shift per cycle, with no bubble at wrap.

Reset
REQ-023 reset_n=0 SHALL asynchronously force r=0, cnt=0, done=0.
REQ-024 Consequently q=0, s_out_r=0 and s_out_l=0 while in reset.
REQ-025 Assertion of reset_n mid-word SHALL discard the partial count; no done pulse SHALL follow reset.
REQ-026 Deassertion SHALL be honoured at the next rising edge of clk; the first operation is sampled on that edge.

Configuration
REQ-027 Macro UNIV_SHIFT_REG_ROTATE_EN SHALL compile in ROR/ROL.
REQ-028 With UNIV_SHIFT_REG_ROTATE_EN defined, codes 100 and 101 operate per REQ-012.
REQ-029 With UNIV_SHIFT_REG_ROTATE_EN undefined, codes 100 and 101 SHALL behave as HOLD and SHALL NOT increment cnt.

Structure
REQ-030 The ctrl encodings (OP_HOLD, OP_SHR, OP_SHL, OP_LOAD, OP_ROR, OP_ROL) SHALL live in shared package univ_shift_reg_pkg.
REQ-031 The counter and done logic SHALL be sub-module shift_bit_cnt (params N, CW; inputs clk, reset_n, clr, inc, ld; outputs cnt, done).
REQ-032 The register datapath SHALL stay in univ_shift_reg.

Verification (N=8 unless stated)
REQ-033 Reset: reset_n=0 mid-operation -> q=8'h00, cnt=0, done=0 immediately, without waiting for a clock edge.
REQ-034 Load and shift right: LOAD d=8'hA5, then 8x SHR with s_in_l=0 -> s_out_r sequence 1,0,1,0,0,1,0,1; q=8'h00 at end; done=1 exactly in the cycle after the 8th shift.
REQ-035 Shift left: LOAD 8'h81, then SHL with s_in_r=1 -> q=8'h03, s_out_l=0, cnt=1.
REQ-036 Rotate (macro defined): LOAD 8'h01, then 8x ROL -> q returns to 8'h01 and done pulses once. With the macro undefined -> q stays 8'h01 and cnt=0.
REQ-037 Clear and enable: clr=1 together with en=1, ctrl=SHR -> q=0, cnt=0. en=0 with ctrl=LOAD, d=8'hFF -> q unchanged.
REQ-038 Non-power-of-two width (N=5): 10 consecutive SHR -> done pulses after the 5th and 10th shift; cnt never exceeds 4.
